// File: rtl/pcimid_pkg.sv
// Shared constants and FSM encoding for the PC / instruction-memory fetch path.
package pcimid_pkg;

  localparam int ADDR_W      = 8;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FULL   = 2'd1,
    HALTED = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} words; head is read combinationally.
module ifu_fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (srst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC register, FETCH/FULL/HALTED FSM and queue towards decode.
// Optional handshake counter on FetchCount when IFU_PERF_CNT_EN is defined.
module instruction_fetch_unit
  import pcimid_pkg::*;
#(
  parameter int                ADDR_W   = pcimid_pkg::ADDR_W,
  parameter int                INSTR_W  = pcimid_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = pcimid_pkg::RESET_PC,
  parameter int                QDEPTH   = 2
) (
  input  logic               Clk,
  input  logic               Rst,
  output logic [ADDR_W-1:0]  Address,
  input  logic [INSTR_W-1:0] InstructionOut,
  output logic               IDValid,
  input  logic               IDReady,
  output logic [INSTR_W-1:0] IDInstr,
  output logic [ADDR_W-1:0]  IDPC,
  input  logic               RedirectValid,
  input  logic [ADDR_W-1:0]  RedirectPC,
  input  logic               Halt,
  output logic               Halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]        FetchCount
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [ADDR_W-1:0]         pc_q, pc_d;
  ifu_state_t                state_q, state_d;
  logic [ADDR_W-1:0]         last_pc_q;
  logic [INSTR_W-1:0]        last_instr_q;
  logic [ADDR_W+INSTR_W-1:0] q_head;
  logic [CW-1:0]             q_count;
  logic [CW-1:0]             cnt_next;
  logic                      q_full, q_empty;
  logic                      push, pop;

  assign pop  = !q_empty && IDReady;
  assign push = (state_q != HALTED) && !Halt && !RedirectValid && (!q_full || pop);

  ifu_fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (ADDR_W + INSTR_W)
  ) u_queue (
    .clk     (Clk),
    .srst    (Rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (RedirectValid),
    .data_i  ({pc_q, InstructionOut}),
    .head_o  (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_comb begin
    cnt_next = q_count;
    if (RedirectValid)     cnt_next = '0;
    else if (push && !pop) cnt_next = q_count + 1'b1;
    else if (pop && !push) cnt_next = q_count - 1'b1;
  end

  // Halt wins for state even when a redirect updates the PC in the same cycle.
  always_comb begin
    state_d = FETCH;
    if (Halt)                              state_d = HALTED;
    else if (state_q == HALTED)            state_d = FETCH;
    else if (cnt_next == CW'(QDEPTH))      state_d = FULL;
  end

  always_comb begin
    pc_d = pc_q;
    if (RedirectValid) pc_d = {RedirectPC[ADDR_W-1:2], 2'b00};
    else if (push)     pc_d = pc_q + ADDR_W'(INSTR_BYTES);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q         <= RESET_PC;
      state_q      <= FETCH;
      last_pc_q    <= '0;
      last_instr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      if (!q_empty) begin
        last_pc_q    <= q_head[ADDR_W+INSTR_W-1:INSTR_W];
        last_instr_q <= q_head[INSTR_W-1:0];
      end
    end
  end

  // Decode sees the most recent head while the queue is empty.
  assign IDValid = !q_empty;
  assign IDPC    = q_empty ? last_pc_q    : q_head[ADDR_W+INSTR_W-1:INSTR_W];
  assign IDInstr = q_empty ? last_instr_q : q_head[INSTR_W-1:0];
  assign Address = pc_q;
  assign Halted  = (state_q == HALTED);

`ifdef IFU_PERF_CNT_EN
  logic [15:0] fetch_cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst)                       fetch_cnt_q <= '0;
    else if (pop && !(&fetch_cnt_q)) fetch_cnt_q <= fetch_cnt_q + 16'd1;
  end

  assign FetchCount = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, backpressure, redirect, halt, wrap, reset.
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [7:0]  Address;
  logic [31:0] InstructionOut;
  logic        IDValid, IDReady;
  logic [31:0] IDInstr;
  logic [7:0]  IDPC;
  logic        RedirectValid;
  logic [7:0]  RedirectPC;
  logic        Halt, Halted;

  logic [7:0]  w_address;
  logic [31:0] w_instr_out;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [7:0]  w_pc;
  logic        w_halted;
`ifdef IFU_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] w_fetch_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  // Instruction memory: word k lives at byte address 4k.
  function automatic logic [31:0] word(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  assign InstructionOut = word(int'(Address >> 2));
  assign w_instr_out    = word(int'(w_address >> 2));

  instruction_fetch_unit dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Address        (Address),
    .InstructionOut (InstructionOut),
    .IDValid        (IDValid),
    .IDReady        (IDReady),
    .IDInstr        (IDInstr),
    .IDPC           (IDPC),
    .RedirectValid  (RedirectValid),
    .RedirectPC     (RedirectPC),
    .Halt           (Halt),
    .Halted         (Halted)
`ifdef IFU_PERF_CNT_EN
    ,
    .FetchCount     (fetch_count)
`endif
  );

  instruction_fetch_unit #(.RESET_PC(8'hF8)) dut_wrap (
    .Clk            (Clk),
    .Rst            (Rst),
    .Address        (w_address),
    .InstructionOut (w_instr_out),
    .IDValid        (w_valid),
    .IDReady        (1'b1),
    .IDInstr        (w_instr),
    .IDPC           (w_pc),
    .RedirectValid  (1'b0),
    .RedirectPC     (8'h00),
    .Halt           (1'b0),
    .Halted         (w_halted)
`ifdef IFU_PERF_CNT_EN
    ,
    .FetchCount     (w_fetch_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-18s = %h", tag, got);
    end else begin
      $display("FAIL %-18s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1; IDReady = 1'b1; RedirectValid = 1'b0; RedirectPC = 8'h00; Halt = 1'b0;
    step();
    check("rst_valid",  32'(IDValid), 32'd0);
    check("rst_halted", 32'(Halted),  32'd0);
    check("rst_instr",  IDInstr,      32'd0);
    check("rst_idpc",   32'(IDPC),    32'd0);
    check("rst_addr",   32'(Address), 32'h00);
    check("rst_addr_w", 32'(w_address), 32'hF8);
    check("rst_valid_w", 32'(w_valid), 32'd0);
    Rst = 1'b0;

    // Streaming with IDReady=1, plus the wrapping instance alongside.
    for (int k = 0; k < 6; k++) begin
      step();
      check("s_valid", 32'(IDValid), 32'd1);
      check("s_idpc",  32'(IDPC), 32'(8'(4 * k)));
      check("s_instr", IDInstr, word(k));
      check("s_addr",  32'(Address), 32'(8'(4 * (k + 1))));
      if (k < 4) check("wrap_idpc", 32'(w_pc), 32'(8'(8'hF8 + 8'(4 * k))));
    end

    // Backpressure from a clean reset.
    Rst = 1'b1; IDReady = 1'b0;
    step();
    Rst = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("bp_addr",   32'(Address), 32'h08);
    check("bp_valid",  32'(IDValid), 32'd1);
    check("bp_idpc",   32'(IDPC), 32'h00);
    IDReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("drain_idpc",  32'(IDPC), 32'(8'(4 * k)));
      check("drain_instr", IDInstr, word(k));
      step();
    end
    check("drain_addr", 32'(Address), 32'h14);

    // Redirect while the queue is full.
    IDReady = 1'b0; RedirectValid = 1'b1; RedirectPC = 8'h23;
    step();
    RedirectValid = 1'b0; IDReady = 1'b1;
    check("redir_valid", 32'(IDValid), 32'd0);
    check("redir_addr",  32'(Address), 32'h20);
    step();
    check("redir_idpc",  32'(IDPC), 32'h20);
    check("redir_instr", IDInstr, word(8));
    check("redir_addr2", 32'(Address), 32'h24);

    // Halt with two entries queued.
    IDReady = 1'b0;
    step();
    check("pre_halt_addr", 32'(Address), 32'h28);
    Halt = 1'b1;
    step();
    check("halt_halted", 32'(Halted), 32'd1);
    check("halt_addr",   32'(Address), 32'h28);
    IDReady = 1'b1;
    check("halt_d0_idpc", 32'(IDPC), 32'h20);
    step();
    check("halt_d1_idpc", 32'(IDPC), 32'h24);
    check("halt_d1_valid", 32'(IDValid), 32'd1);
    step();
    check("halt_empty", 32'(IDValid), 32'd0);
    step();
    check("halt_empty2", 32'(IDValid), 32'd0);
    check("halt_frozen", 32'(Address), 32'h28);
    check("halt_still",  32'(Halted), 32'd1);
    Halt = 1'b0;
    step();
    check("unhalt_halted", 32'(Halted), 32'd0);
    check("unhalt_addr",   32'(Address), 32'h28);
    step();
    check("resume_idpc",  32'(IDPC), 32'h28);
    check("resume_instr", IDInstr, word(10));
    check("resume_addr",  32'(Address), 32'h2C);

    // Mid-stream reset with the queue full.
    IDReady = 1'b0;
    step();
    step();
    check("full_valid", 32'(IDValid), 32'd1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("mrst_valid", 32'(IDValid), 32'd0);
    check("mrst_addr",  32'(Address), 32'h00);
    check("mrst_instr", IDInstr, 32'd0);
`ifdef IFU_PERF_CNT_EN
    check("cnt_reset", 32'(fetch_count), 32'd0);
`endif
    IDReady = 1'b1;
    for (int k = 0; k < 11; k++) step();
    check("post_addr", 32'(Address), 32'h2C);
    check("post_idpc", 32'(IDPC), 32'h28);
`ifdef IFU_PERF_CNT_EN
    check("cnt_10", 32'(fetch_count), 32'd10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
